aes_sub_bytes_iter: RTL and testbench
=====================================

# aes_sub_bytes_iter

Iterative, parametrised SubBytes/InvSubBytes unit. It substitutes a 128-bit AES block in place over 16/LANES clock cycles, using LANES byte-wide S-box lanes, behind valid/ready handshakes on both sides. It is the area-scalable successor to the combinational 16-lane substitution stage, for round datapaths that trade latency for S-box count. Direction (encrypt or decrypt) is selected per block.

## Interface
- LANES, default 4: bytes substituted per cycle. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- enc  input  1  mode, sampled on input handshake: 1 = SubBytes (S-box), 0 = InvSubBytes (inverse S-box).
- in_valid  input  1  in_block and enc are valid.
- in_ready  output  1  unit can accept a block this cycle.
- in_block  input  `AES_BLOCK_SIZE  block to substitute; byte i is in_block[8*i +: 8].
- out_valid  output  1  out_block holds a finished result.
- out_ready  input  1  consumer accepts out_block this cycle.
- out_block  output  `AES_BLOCK_SIZE  substituted block, same byte order as in_block.

## Operation
- Constants:
  - N = 16/LANES (number of groups).
  - Group g covers bytes g*LANES through g*LANES+LANES-1.
- State machine: IDLE, BUSY, DONE.
  - Registers: data (128 b), mode (1 b), group counter cnt (width max(1,$clog2(N))).
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: data<=in_block, mode<=enc, cnt<=0, go to BUSY.
- BUSY:
  - Each cycle, replace group cnt of data with its S-box (mode=1) or inverse S-box (mode=0) image. All other bytes hold.
  - When cnt==N-1: go to DONE and clear cnt to 0. Otherwise cnt<=cnt+1.
- DONE:
  - out_valid=1 and out_block=data. Both are held stable until out_ready.
  - On out_ready: if in_valid, load the new block (as in IDLE) and go to BUSY; otherwise go to IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This is a combinational path from out_ready and allows back-to-back blocks.
- enc and in_block are ignored outside the input handshake. Changing enc during BUSY has no effect.
- out_block = data in every state. It is don't-care when out_valid=0, but is never X after reset.

## Timing
- Reset (rst=1 at an edge): state=IDLE, cnt=0, data=0, mode=1.
  - While rst=1: in_ready=0, out_valid=0, out_block=0.
  - Reset mid-BUSY or mid-DONE discards the block. No output handshake occurs.
- Latency: input handshake at edge t gives out_valid=1 from the cycle after edge t+N.
  - LANES=16: 1 BUSY cycle.
  - LANES=1: 16 BUSY cycles.
- Throughput:
  - With out_ready held high and in_valid always high: one block per N+1 cycles.
  - Otherwise N+2 cycles (passes through IDLE).
- Backpressure: DONE holds indefinitely. No data loss, no overwrite.
- Simultaneous output and input handshake in DONE: the new block is loaded at the same edge the old result is consumed.
- No bypass: a block never appears at the output in the cycle it is accepted.

## Structure
- `AES_BLOCK_SIZE and the legal-LANES check macro go in aes_defines.svh. No new package is needed.
- Sub-module aes_sbox_lane: one byte lane with enc select, built from aes_sbox and aes_inv_sbox plus a 2:1 mux. Instantiate it LANES times in a generate loop.
- Group select: the lane inputs are data[8*(cnt*LANES+j) +: 8]. Write-back uses the same indexed part-select; no per-byte comparators.

## Test plan
- LANES=4, enc=1, in_block=all 0x00 → out_valid 4 cycles after the handshake; out_block=all 0x63.
- LANES=1, enc=0, in_block=all 0x63 → out_block=all 0x00 after 16 cycles; during BUSY, bytes ≥cnt still read 0x63.
- LANES=2, enc=1, byte 5=0x53 and other bytes 0x00 → byte 5=0xED, others 0x63. Then enc=0 on that result → the original block is restored.
- LANES=16, FIPS-197 round-1 state: bytes 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08 with enc=1 → d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30 after 1 cycle.
- LANES=4, out_ready low for 10 cycles in DONE → out_block stable and in_ready=0. Then out_ready=1 with in_valid=1 → new block accepted at the same edge; next out_valid 4 cycles later.
- LANES=8, rst pulsed during BUSY, with enc toggled mid-block in a second run → outputs go to reset values and no out_valid follows. The toggled block still uses the sampled mode.

Source files
------------

// File: rtl/aes_sub_bytes_iter_pkg.sv
// Types and GF(2^8) helpers for the iterative SubBytes unit.
// The S-box is computed as multiplicative inverse plus affine map instead
// of storing two 256-entry tables.
package aes_sub_bytes_iter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Rotate a byte left by k bit positions.
   function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
      return (b << k) | (b >> (8 - k));
   endfunction

   // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Inverse as a^254 (maps 0 to 0, as AES requires).
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] res;
      sq  = a;
      res = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq  = gf_mul(sq, sq);
         res = gf_mul(res, sq);
      end
      return res;
   endfunction

   // Forward S-box: inverse followed by the affine transform.
   function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
      logic [7:0] v;
      v = gf_inv(b);
      return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
   endfunction

   // Inverse S-box: inverse affine transform followed by the inverse.
   function automatic logic [7:0] sbox_inv(input logic [7:0] s);
      logic [7:0] t;
      t = rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05;
      return gf_inv(t);
   endfunction

endpackage

// File: rtl/aes_defines.svh
// Shared AES macros: block width and the legal lane-count test.
`ifndef AES_DEFINES_SVH
`define AES_DEFINES_SVH

`define AES_BLOCK_SIZE 128

// True when a lane count divides the 16-byte block into whole groups.
`define AES_LANES_LEGAL(l) (((l) == 1) || ((l) == 2) || ((l) == 4) || ((l) == 8) || ((l) == 16))

`endif

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box, one byte, purely combinational.
module aes_inv_sbox
   import aes_sub_bytes_iter_pkg::*;
(
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   assign out_byte = sbox_inv(in_byte);

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte, purely combinational.
module aes_sbox
   import aes_sub_bytes_iter_pkg::*;
(
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   assign out_byte = sbox_fwd(in_byte);

endmodule

// File: rtl/aes_sbox_lane.sv
// One byte lane: forward and inverse S-box with a direction select.
module aes_sbox_lane (
   input  logic       enc,
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   logic [7:0] fwd_byte;
   logic [7:0] inv_byte;

   aes_sbox u_fwd (
      .in_byte  (in_byte),
      .out_byte (fwd_byte)
   );

   aes_inv_sbox u_inv (
      .in_byte  (in_byte),
      .out_byte (inv_byte)
   );

   assign out_byte = enc ? fwd_byte : inv_byte;

endmodule

// File: rtl/aes_sub_bytes_iter.sv
// Iterative SubBytes/InvSubBytes: substitutes a 128-bit block in place,
// LANES bytes per cycle, with valid/ready handshakes on input and output.
`include "aes_defines.svh"

module aes_sub_bytes_iter
   import aes_sub_bytes_iter_pkg::*;
#(
   parameter int LANES = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enc,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [`AES_BLOCK_SIZE-1:0] in_block,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [`AES_BLOCK_SIZE-1:0] out_block
);

   localparam int N  = 16 / LANES;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   if (!`AES_LANES_LEGAL(LANES)) begin : g_lanes_illegal
      $error("aes_sub_bytes_iter: LANES=%0d must be 1, 2, 4, 8 or 16", LANES);
   end

   state_t                     state, state_nxt;
   logic [`AES_BLOCK_SIZE-1:0] data, data_nxt;
   logic                       mode, mode_nxt;
   logic [CW-1:0]              cnt, cnt_nxt;
   logic                       in_ready_raw;
   logic                       out_valid_raw;

   logic [LANES-1:0][7:0]      lane_in;
   logic [LANES-1:0][7:0]      lane_out;

   // Lanes read the group selected by cnt; the mode chosen at load steers them.
   for (genvar j = 0; j < LANES; j++) begin : g_lane
      assign lane_in[j] = data[8*(int'(cnt)*LANES + j) +: 8];

      aes_sbox_lane u_lane (
         .enc      (mode),
         .in_byte  (lane_in[j]),
         .out_byte (lane_out[j])
      );
   end

   // State, block and group counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         data  <= '0;
         mode  <= 1'b1;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         data  <= data_nxt;
         mode  <= mode_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state logic: load on input handshake, substitute one group per
   // BUSY cycle, hold the result in DONE until the consumer takes it.
   always_comb begin
      state_nxt     = state;
      data_nxt      = data;
      mode_nxt      = mode;
      cnt_nxt       = cnt;
      in_ready_raw  = 1'b0;
      out_valid_raw = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready_raw = 1'b1;
            if (in_valid) begin
               data_nxt  = in_block;
               mode_nxt  = enc;
               cnt_nxt   = '0;
               state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            for (int j = 0; j < LANES; j++) begin
               data_nxt[8*(int'(cnt)*LANES + j) +: 8] = lane_out[j];
            end
            if (cnt == CW'(N - 1)) begin
               cnt_nxt   = '0;
               state_nxt = ST_DONE;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         ST_DONE: begin
            out_valid_raw = 1'b1;
            in_ready_raw  = out_ready;
            if (out_ready) begin
               if (in_valid) begin
                  data_nxt  = in_block;
                  mode_nxt  = enc;
                  cnt_nxt   = '0;
                  state_nxt = ST_BUSY;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Outputs are forced quiet while reset is held, even before the first edge.
   assign in_ready  = in_ready_raw & ~rst;
   assign out_valid = out_valid_raw & ~rst;
   assign out_block = rst ? '0 : data;

endmodule

// File: tb/tb_aes_sub_bytes_iter.sv
// Directed bench for aes_sub_bytes_iter: one instance per legal LANES value,
// expected blocks are hand-derived S-box values and FIPS-197 vectors.
module tb_aes_sub_bytes_iter;

   localparam int NI = 5;

   localparam logic [127:0] ALL00    = 128'h0;
   localparam logic [127:0] ALL63    = {16{8'h63}};
   localparam logic [127:0] B53      = 128'h00000000_00000000_00005300_00000000;
   localparam logic [127:0] E53      = 128'h63636363_63636363_6363ed63_63636363;
   localparam logic [127:0] FIPS_IN  = 128'h0848f8e9_2a8dc69a_2be2f4a0_bee33d19;
   localparam logic [127:0] FIPS_OUT = 128'h3052411e_e55db4b8_f198bfe0_ae1127d4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NI-1:0]     enc = '0;
   logic [NI-1:0]     in_valid = '0;
   logic [NI-1:0]     out_ready = '0;
   logic [127:0]      in_block [NI];
   wire  [NI-1:0]     in_ready;
   wire  [NI-1:0]     out_valid;
   wire  [127:0]      out_block [NI];

   int checks   = 0;
   int failures = 0;
   int cyc;
   logic seen;
   logic stable;
   logic [127:0] expv;

   // Instance k has LANES = 2**k: 1, 2, 4, 8, 16.
   for (genvar k = 0; k < NI; k++) begin : g_dut
      aes_sub_bytes_iter #(.LANES(1 << k)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .enc       (enc[k]),
         .in_valid  (in_valid[k]),
         .in_ready  (in_ready[k]),
         .in_block  (in_block[k]),
         .out_valid (out_valid[k]),
         .out_ready (out_ready[k]),
         .out_block (out_block[k])
      );
   end

   // Free-running clock.
   always #5 clk = ~clk;

   // Hard stop in case a bounded wait is somehow bypassed.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [127:0] actual,
                              input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
      end
   endtask

   // Offer a block to instance k and return #1 after the accepting edge;
   // enc and in_block are scrambled afterwards, which must have no effect.
   task automatic applyStimulus(input int k, input logic e, input logic [127:0] blk);
      int n;
      @(negedge clk);
      enc[k]      = e;
      in_block[k] = blk;
      in_valid[k] = 1'b1;
      n = 0;
      while (!in_ready[k] && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("in_handshake", {127'b0, in_ready[k]}, 128'd1);
      @(posedge clk);
      #1;
      in_valid[k] = 1'b0;
      in_block[k] = {4{32'hdeadbeef}};
      enc[k]      = ~e;
   endtask

   // Count edges after the input handshake until out_valid is seen.
   task automatic waitDone(input int k, output int cycles);
      cycles = 0;
      do begin
         @(posedge clk);
         cycles++;
         @(negedge clk);
      end while (!out_valid[k] && cycles < 40);
   endtask

   task automatic consume(input int k);
      @(negedge clk);
      out_ready[k] = 1'b1;
      @(posedge clk);
      #1;
      out_ready[k] = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < NI; k++) in_block[k] = '0;

      // Reset behaviour.
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      checkOutput("rst_in_ready", {123'b0, in_ready}, 128'd0);
      checkOutput("rst_out_valid", {123'b0, out_valid}, 128'd0);
      checkOutput("rst_block_l4", out_block[2], ALL00);
      checkOutput("rst_block_l16", out_block[4], ALL00);
      rst = 1'b0;
      #1;
      checkOutput("idle_in_ready", {123'b0, in_ready}, 128'h1f);
      checkOutput("idle_out_valid", {123'b0, out_valid}, 128'd0);

      // LANES=4 forward on zeros.
      applyStimulus(2, 1'b1, ALL00);
      checkOutput("l4_busy_no_ready", {127'b0, in_ready[2]}, 128'd0);
      waitDone(2, cyc);
      checkOutput("l4_latency", cyc, 128'd4);
      checkOutput("l4_block", out_block[2], ALL63);
      consume(2);
      checkOutput("l4_consumed_valid", {127'b0, out_valid[2]}, 128'd0);
      checkOutput("l4_consumed_ready", {127'b0, in_ready[2]}, 128'd1);

      // LANES=1 inverse on 0x63; unprocessed bytes stay 0x63 during BUSY.
      applyStimulus(0, 1'b0, ALL63);
      cyc = 0;
      do begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (!out_valid[0] && (cyc == 1 || cyc == 8 || cyc == 15)) begin
            expv = ALL63;
            for (int i = 0; i < cyc; i++) expv[8*i +: 8] = 8'h00;
            checkOutput("l1_busy_partial", out_block[0], expv);
         end
      end while (!out_valid[0] && cyc < 40);
      checkOutput("l1_latency", cyc, 128'd16);
      checkOutput("l1_block", out_block[0], ALL00);
      consume(0);

      // LANES=2 single odd byte, then inverted back.
      applyStimulus(1, 1'b1, B53);
      waitDone(1, cyc);
      checkOutput("l2_latency", cyc, 128'd8);
      checkOutput("l2_fwd_block", out_block[1], E53);
      consume(1);
      applyStimulus(1, 1'b0, E53);
      waitDone(1, cyc);
      checkOutput("l2_inv_block", out_block[1], B53);
      consume(1);

      // LANES=16 FIPS-197 round-1 SubBytes and its inverse.
      applyStimulus(4, 1'b1, FIPS_IN);
      waitDone(4, cyc);
      checkOutput("l16_latency", cyc, 128'd1);
      checkOutput("l16_fwd_block", out_block[4], FIPS_OUT);
      consume(4);
      applyStimulus(4, 1'b0, FIPS_OUT);
      waitDone(4, cyc);
      checkOutput("l16_inv_block", out_block[4], FIPS_IN);
      consume(4);

      // LANES=4 backpressure, then simultaneous output/input handshake.
      applyStimulus(2, 1'b1, ALL00);
      waitDone(2, cyc);
      enc[2]      = 1'b1;
      in_block[2] = FIPS_IN;
      in_valid[2] = 1'b1;
      #1;
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (out_block[2] !== ALL63 || in_ready[2] !== 1'b0 || out_valid[2] !== 1'b1)
            stable = 1'b0;
         @(negedge clk);
      end
      checkOutput("bp_held", {127'b0, stable}, 128'd1);
      checkOutput("bp_block", out_block[2], ALL63);
      out_ready[2] = 1'b1;
      #1;
      checkOutput("bp_comb_ready", {127'b0, in_ready[2]}, 128'd1);
      @(posedge clk);
      #1;
      out_ready[2] = 1'b0;
      in_valid[2]  = 1'b0;
      enc[2]       = 1'b0;
      checkOutput("bp_after_swap_valid", {127'b0, out_valid[2]}, 128'd0);
      waitDone(2, cyc);
      checkOutput("bp_next_latency", cyc, 128'd4);
      checkOutput("bp_next_block", out_block[2], FIPS_OUT);
      consume(2);

      // LANES=8 reset mid-BUSY discards the block.
      applyStimulus(3, 1'b1, ALL00);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("l8_rst_in_ready", {127'b0, in_ready[3]}, 128'd0);
      checkOutput("l8_rst_out_valid", {127'b0, out_valid[3]}, 128'd0);
      checkOutput("l8_rst_block", out_block[3], ALL00);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("l8_post_rst_block", out_block[3], ALL00);
      checkOutput("l8_post_rst_ready", {127'b0, in_ready[3]}, 128'd1);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (out_valid[3]) seen = 1'b1;
      end
      checkOutput("l8_no_out_valid", {127'b0, seen}, 128'd0);

      // LANES=8 inverse with enc flipped right after acceptance.
      applyStimulus(3, 1'b0, ALL63);
      @(negedge clk);
      enc[3] = 1'b0;
      #1;
      enc[3] = 1'b1;
      waitDone(3, cyc);
      checkOutput("l8_latency", cyc, 128'd1 + 128'd1);
      checkOutput("l8_sampled_mode", out_block[3], ALL00);
      consume(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
